ql_sys_clk_macro: RTL and testbench

//   Synthesizable stand-in for the FPGA cell macro's system-clock service.

---
 rtl/ql_clk_pkg.sv | 20 ++
 rtl/ql_clk_div_chan.sv | 74 +++++++
 rtl/ql_sys_clk_macro.sv | 50 +++++
 tb/tb_ql_sys_clk_macro.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/ql_clk_pkg.sv
// ============================================================================
// Module      : ql_clk_pkg
// Description : Shared widths and helpers for the system-clock divider slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ql_clk_pkg;

    localparam int CNT_W  = 16;
    localparam int RSTC_W = 8;

    // High-phase length of a divided clock; odd dividers spend the extra cycle low.
    function automatic int half(input int div);
        return div / 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ql_clk_div_chan.sv
// ============================================================================
// Module      : ql_clk_div_chan
// Description : One divided-clock channel: free-running divider, period-aligned
//               enable and a reset stretcher counted in divided-clock ticks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ql_clk_div_chan
    import ql_clk_pkg::*;
#(
    parameter int DIV        = 4,
    parameter int RST_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_clk,
    output logic o_rst
);

    generate
        if (DIV < 2 || DIV > 65535) begin : g_bad_div
            $error("ql_clk_div_chan: DIV out of range 2..65535");
        end
        if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : g_bad_rst_cycles
            $error("ql_clk_div_chan: RST_CYCLES out of range 1..255");
        end
    endgenerate

    localparam logic [CNT_W-1:0]  c_LAST     = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  c_HIGH     = CNT_W'(half(DIV));
    localparam logic [RSTC_W-1:0] c_RST_LAST = RSTC_W'(RST_CYCLES - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [RSTC_W-1:0] r_rst_cnt;
    logic              r_en_q;
    logic              r_clk;
    logic              r_rst_out;

    logic w_tick;
    logic w_en_eff;

    // Enable is only sampled at the ungated rising edge, so pulses are never cut short.
    assign w_tick   = (r_cnt == '0);
    assign w_en_eff = w_tick ? i_en : r_en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_en_q    <= 1'b0;
            r_clk     <= 1'b0;
            r_rst_out <= 1'b1;
            r_rst_cnt <= '0;
        end else begin
            r_cnt  <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
            r_en_q <= w_en_eff;
            r_clk  <= (r_cnt < c_HIGH) & w_en_eff;
            // Ticks are counted even while disabled so reset release is enable-independent.
            if (r_rst_out && w_tick) begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
                if (r_rst_cnt == c_RST_LAST) begin
                    r_rst_out <= 1'b0;
                end
            end
        end
    end

    assign o_clk = r_clk;
    assign o_rst = r_rst_out;

endmodule

`default_nettype wire

// File: rtl/ql_sys_clk_macro.sv
// ============================================================================
// Module      : ql_sys_clk_macro
// Description : System-clock service: two divided fabric clocks, each with a
//               stretched reset and a glitch-free enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ql_sys_clk_macro
    import ql_clk_pkg::*;
#(
    parameter int CLK0_DIV   = 4,
    parameter int CLK1_DIV   = 8,
    parameter int RST_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clk0_en,
    input  logic clk1_en,
    output logic Sys_Clk0,
    output logic Sys_Clk0_Rst,
    output logic Sys_Clk1,
    output logic Sys_Clk1_Rst
);

    ql_clk_div_chan #(
        .DIV        (CLK0_DIV),
        .RST_CYCLES (RST_CYCLES)
    ) u_chan0 (
        .clk   (clk),
        .rst   (rst),
        .i_en  (clk0_en),
        .o_clk (Sys_Clk0),
        .o_rst (Sys_Clk0_Rst)
    );

    ql_clk_div_chan #(
        .DIV        (CLK1_DIV),
        .RST_CYCLES (RST_CYCLES)
    ) u_chan1 (
        .clk   (clk),
        .rst   (rst),
        .i_en  (clk1_en),
        .o_clk (Sys_Clk1),
        .o_rst (Sys_Clk1_Rst)
    );

endmodule

`default_nettype wire

// File: tb/tb_ql_sys_clk_macro.sv
// ============================================================================
// Module      : tb_ql_sys_clk_macro
// Description : Self-checking bench for ql_sys_clk_macro (DIV0=4, DIV1=5, RST=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ql_sys_clk_macro;

    localparam int D0 = 4;
    localparam int D1 = 5;
    localparam int RC = 4;

    logic clk = 1'b0;
    logic rst, clk0_en, clk1_en;
    logic Sys_Clk0, Sys_Clk0_Rst, Sys_Clk1, Sys_Clk1_Rst;

    int n_pass  = 0;
    int n_total = 0;
    bit model_on = 1'b0;

    ql_sys_clk_macro #(
        .CLK0_DIV   (D0),
        .CLK1_DIV   (D1),
        .RST_CYCLES (RC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk0_en      (clk0_en),
        .clk1_en      (clk1_en),
        .Sys_Clk0     (Sys_Clk0),
        .Sys_Clk0_Rst (Sys_Clk0_Rst),
        .Sys_Clk1     (Sys_Clk1),
        .Sys_Clk1_Rst (Sys_Clk1_Rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: k = edges since reset release; edge k+1 sits at phase k%DIV.
    int  k0, k1;
    bit  pen0, pen1;
    bit  e_clk0, e_rst0, e_clk1, e_rst1;

    always @(posedge clk) begin
        if (rst) begin
            k0 = 0; k1 = 0; pen0 = 0; pen1 = 0;
            e_clk0 = 0; e_clk1 = 0; e_rst0 = 1; e_rst1 = 1;
        end else begin
            if (k0 % D0 == 0) pen0 = clk0_en;
            if (k1 % D1 == 0) pen1 = clk1_en;
            e_clk0 = pen0 && ((k0 % D0) < D0 / 2);
            e_clk1 = pen1 && ((k1 % D1) < D1 / 2);
            k0++; k1++;
            e_rst0 = (k0 < (RC - 1) * D0 + 1);
            e_rst1 = (k1 < (RC - 1) * D1 + 1);
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("model_clk0", int'(Sys_Clk0), int'(e_clk0));
            check("model_rst0", int'(Sys_Clk0_Rst), int'(e_rst0));
            check("model_clk1", int'(Sys_Clk1), int'(e_clk1));
            check("model_rst1", int'(Sys_Clk1_Rst), int'(e_rst1));
        end
    end

    // Release reset, then check the 1,1,0,0 pattern and both reset releases.
    task automatic release_and_check(input string tag);
        logic [7:0] pat;
        pat = 8'b11001100;
        rst = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            @(negedge clk);
            if (e <= 8) check({tag, "_pattern"}, int'(Sys_Clk0), int'(pat[8-e]));
            if (e == 12) check({tag, "_rst0_held"}, int'(Sys_Clk0_Rst), 1);
            if (e == 13) check({tag, "_rst0_rel"}, int'(Sys_Clk0_Rst), 0);
            if (e == 15) check({tag, "_rst1_held"}, int'(Sys_Clk1_Rst), 1);
            if (e == 16) check({tag, "_rst1_rel"}, int'(Sys_Clk1_Rst), 0);
        end
    endtask

    initial begin
        int highs, rises, zeros;
        logic prev;
        logic [6:0] seq;

        rst = 1'b1; clk0_en = 1'b0; clk1_en = 1'b0;
        @(negedge clk);
        model_on = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_clk0", int'(Sys_Clk0), 0);
        check("reset_rst0", int'(Sys_Clk0_Rst), 1);
        check("reset_rst1", int'(Sys_Clk1_Rst), 1);

        // Tests 1 and 3
        clk0_en = 1'b1; clk1_en = 1'b1;
        release_and_check("t1");

        // Test 2: 100 periods of the DIV=5 clock
        highs = 0; rises = 0; prev = Sys_Clk1;
        for (int i = 0; i < 100 * D1; i++) begin
            @(negedge clk);
            if (Sys_Clk1) highs++;
            if (Sys_Clk1 && !prev) rises++;
            prev = Sys_Clk1;
        end
        check("t2_high_cycles", highs, 200);
        check("t2_rising_edges", rises, 100);

        // Test 4: drop enable just before the cnt==1 edge
        for (int i = 0; i < D0 && (k0 % D0) != 1; i++) @(negedge clk);
        clk0_en = 1'b0;
        seq = 7'b1000000;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("t4_drop", int'(Sys_Clk0), int'(seq[6-i]));
        end
        @(negedge clk);
        clk0_en = 1'b1;
        seq = 7'b0001100;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("t4_reenable", int'(Sys_Clk0), int'(seq[6-i]));
        end

        // Test 5: one-cycle rst mid-period
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_clk0_low", int'(Sys_Clk0), 0);
        check("t5_rst0_high", int'(Sys_Clk0_Rst), 1);
        check("t5_rst1_high", int'(Sys_Clk1_Rst), 1);
        release_and_check("t5");

        // Test 6: channel 0 disabled from reset
        rst = 1'b1; clk0_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        zeros = 0;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            if (!Sys_Clk0) zeros++;
            if (e == 12) check("t6_rst0_held", int'(Sys_Clk0_Rst), 1);
            if (e == 13) check("t6_rst0_rel", int'(Sys_Clk0_Rst), 0);
        end
        check("t6_clk0_quiet", zeros, 20);

        model_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
